pseudo_spi_rx_intf: RTL and testbench
=====================================

Name: pseudo_spi_rx_intf

Overview:
Receive-side companion of the pseudo-SPI output interface.
- Pulses SEL so the analog device latches its scan data.
- Generates the same two-phase SCLK1/SCLK2 bit clocking and samples the serial return line SPI_SI LSB-first.
- Assembles MEMORY_DATA_WIDTH-bit words and writes DATA_LEN words into SRAM, starting at ADDR_BGN and descending.
- Sits between the CPU-controlled SRAM port and the analog test chip; reports completion via spi_is_done.

Parameters:
MEMORY_DATA_WIDTH, 8, bits per SRAM word and per received word
MEMORY_ADDR_WIDTH, 9, SRAM address width
RESERVED_DATA_LEN, 8, width of DATA_LEN word count
SEL_CYC, 2, cycles SEL is held high before shifting (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
BGN  input  1  level start; rising into IDLE starts transfer, low aborts/clears
ADDR_BGN  input  MEMORY_ADDR_WIDTH  first (highest) SRAM address written
DATA_LEN  input  RESERVED_DATA_LEN  number of words to receive
SPI_SI  input  1  serial data from analog device
SCLK1  output  1  phase-1 shift clock
SCLK2  output  1  phase-2 shift clock
SEL  output  1  capture/select strobe to analog device
A  output  MEMORY_ADDR_WIDTH  SRAM address, 0 when CEN high
D  output  MEMORY_DATA_WIDTH  SRAM write data, 0 when CEN high
CEN  output  1  SRAM chip enable, active low
D_WE  output  1  SRAM write strobe, 1 = write, high only with CEN low
spi_is_done  output  1  transfer complete, held while BGN high

Behaviour:
- Reset (RST=1 at an edge): state IDLE. Address and length counters, shift register, bit and phase counters cleared. SCLK1=SCLK2=SEL=0, CEN=1, D_WE=0, A=0, D=0, spi_is_done=0. RST has priority over BGN.
- BGN=0 at any edge, from any state: next state IDLE, outputs as reset. Mid-transfer this is an abort: no further SRAM write, and a partial word is discarded.
- Outputs are decoded from registered state only; no combinational path from SPI_SI or BGN to outputs.
- States: IDLE, SEL, SHIFT, WRITE, DONE.
- IDLE with BGN=1 at an edge:
  - Load addr<=ADDR_BGN, len<=DATA_LEN.
  - Go to DONE if DATA_LEN==0 (no SEL, no SCLK, no SRAM access); otherwise go to SEL.
- SEL: SEL=1 for exactly SEL_CYC cycles, then SHIFT with bit=0, phase=0.
- SHIFT: each bit occupies 6 cycles, phase 0..5.
  - SCLK1=1 in phase 1; SCLK2=1 in phase 3; never both high.
  - At the edge ending phase 4: shreg <= {SPI_SI, shreg[W-1:1]}, so the first bit received ends in bit 0.
  - After phase 5 of bit W-1, go to WRITE.
- WRITE: one cycle, CEN=0, D_WE=1, A=addr, D=shreg. At its end:
  - If len>1: addr<=addr-1 (modulo 2^MEMORY_ADDR_WIDTH; 0 wraps to all ones), len<=len-1, go to SHIFT with bit=0, phase=0. SEL is not re-pulsed.
  - Otherwise go to DONE.
- DONE: spi_is_done=1; holds until BGN=0 (then IDLE). BGN held high never restarts a transfer.
- Latency: BGN high at edge 0 → SEL during cycles 0..SEL_CYC-1. Each word takes 6W+1 cycles. spi_is_done is first high SEL_CYC + N·(6W+1) cycles after edge 0 (51 for W=8, N=1, SEL_CYC=2).
- Pulse counts: SCLK1 pulses = SCLK2 pulses = N·W per complete transfer.
- DATA_LEN, ADDR_BGN and SPI_SI changes are ignored outside the sampling points defined above.

Test Plan:
- N=1, ADDR_BGN=0x0A0, device drives 0xA5 LSB-first on SCLK2 → single write A=0x0A0, D=0xA5; 8 SCLK1 and 8 SCLK2 pulses; spi_is_done at cycle 51.
- N=3, ADDR_BGN=0x010, words 0x3C, 0x81, 0xFF → writes (0x010,0x3C), (0x00F,0x81), (0x00E,0xFF); SEL high only cycles 0-1; done at cycle 149.
- DATA_LEN=0 → spi_is_done next cycle; SEL, SCLK1 and SCLK2 never high; CEN stays 1.
- ADDR_BGN=0x000, N=2 → writes at 0x000 then 0x1FF.
- BGN dropped during bit 4 of word 2 → IDLE next cycle, no second write, spi_is_done=0. BGN re-raised → fresh transfer from ADDR_BGN.
- RST pulsed in the WRITE cycle → next cycle all outputs at reset values; no write completes after reset; spi_is_done=0 even with BGN held high until BGN toggles low then high.

Source files
------------

// File: rtl/pseudo_spi_rx_intf.sv
// pseudo_spi_rx_intf: receive side of the pseudo-SPI link.
// Strobes SEL so the analog device latches its scan data, then clocks the
// return line with two-phase SCLK1/SCLK2, assembles LSB-first words and
// writes them into SRAM at descending addresses starting at ADDR_BGN.
module pseudo_spi_rx_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8,
  parameter int SEL_CYC           = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         CEN,
  output logic                         D_WE,
  output logic                         spi_is_done
);

  localparam int W      = MEMORY_DATA_WIDTH;
  localparam int AW     = MEMORY_ADDR_WIDTH;
  localparam int LW     = RESERVED_DATA_LEN;
  localparam int BIT_W  = (W > 1) ? $clog2(W) : 1;
  localparam int SELC_W = (SEL_CYC > 1) ? $clog2(SEL_CYC) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(W - 1);
  localparam logic [SELC_W-1:0] SEL_LAST = SELC_W'(SEL_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      addr;
  logic [LW-1:0]      len;
  logic [W-1:0]       shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [2:0]         phase;
  logic [SELC_W-1:0]  sel_cnt;
  // Set once BGN has been seen low; a start needs a fresh rising BGN, so a
  // BGN held high through reset does not launch a transfer on its own.
  logic               bgn_armed;

  // State register; RST has priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start qualifier: armed by any cycle with BGN low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bgn_armed <= 1'b0;
    end else if (!BGN) begin
      bgn_armed <= 1'b1;
    end
  end

  // Next-state and output decode, from registered state only.
  always_comb begin
    state_nxt   = state;
    SCLK1       = 1'b0;
    SCLK2       = 1'b0;
    SEL         = 1'b0;
    CEN         = 1'b1;
    D_WE        = 1'b0;
    A           = '0;
    D           = '0;
    spi_is_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bgn_armed) begin
          state_nxt = (DATA_LEN == '0) ? ST_DONE : ST_SEL;
        end
      end
      ST_SEL: begin
        SEL = 1'b1;
        if (sel_cnt == SEL_LAST) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        SCLK1 = (phase == 3'd1);
        SCLK2 = (phase == 3'd3);
        if (phase == 3'd5 && bit_cnt == BIT_LAST) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        CEN       = 1'b0;
        D_WE      = 1'b1;
        A         = addr;
        D         = shreg;
        state_nxt = (len > LW'(1)) ? ST_SHIFT : ST_DONE;
      end
      ST_DONE: begin
        spi_is_done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // BGN low aborts from any state.
    if (!BGN) begin
      state_nxt = ST_IDLE;
    end
  end

  // Counters and shift register; cleared on reset and on abort so a
  // partial word never survives into the next transfer.
  always_ff @(posedge CLK) begin
    if (RST || !BGN) begin
      addr    <= '0;
      len     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sel_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bgn_armed) begin
            addr    <= ADDR_BGN;
            len     <= DATA_LEN;
            sel_cnt <= '0;
          end
        end
        ST_SEL: begin
          sel_cnt <= sel_cnt + SELC_W'(1);
          bit_cnt <= '0;
          phase   <= '0;
        end
        ST_SHIFT: begin
          if (phase == 3'd4) begin
            shreg <= {SPI_SI, shreg[W-1:1]};
          end
          if (phase == 3'd5) begin
            phase   <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
          end else begin
            phase <= phase + 3'd1;
          end
        end
        ST_WRITE: begin
          bit_cnt <= '0;
          phase   <= '0;
          if (len > LW'(1)) begin
            addr <= addr - AW'(1);
            len  <= len - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Directed bench for pseudo_spi_rx_intf with an analog-device model on the
// serial return line and a queue of expected SRAM writes.
module tb_pseudo_spi_rx_intf;

  localparam int W  = 8;
  localparam int AW = 9;
  localparam int LW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          BGN = 1'b0;
  logic [AW-1:0] ADDR_BGN = '0;
  logic [LW-1:0] DATA_LEN = '0;
  logic          SPI_SI = 1'b0;
  logic          SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done;
  logic [AW-1:0] A;
  logic [W-1:0]  D;

  pseudo_spi_rx_intf #(
    .MEMORY_DATA_WIDTH(W),
    .MEMORY_ADDR_WIDTH(AW),
    .RESERVED_DATA_LEN(LW),
    .SEL_CYC(2)
  ) dut (
    .CLK(CLK), .RST(RST), .BGN(BGN), .ADDR_BGN(ADDR_BGN), .DATA_LEN(DATA_LEN),
    .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2), .SEL(SEL), .A(A), .D(D),
    .CEN(CEN), .D_WE(D_WE), .spi_is_done(spi_is_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  act_log[0:63];
  int   act_n = 0;
  int   sclk1_n = 0, sclk2_n = 0, sel_n = 0, viol_n = 0;
  int   b_s1, b_s2, b_sel, b_act;
  logic [W-1:0] dev_words[0:7];
  int   dev_idx = 0;

  // Bus monitor: pulse counts, SRAM write log, protocol invariants.
  always @(negedge CLK) begin
    if (SCLK1) sclk1_n++;
    if (SCLK2) sclk2_n++;
    if (SEL) sel_n++;
    if (SCLK1 && SCLK2) viol_n++;
    if (D_WE && CEN) viol_n++;
    if (CEN && (A != '0 || D != '0)) viol_n++;
    if (D_WE && !CEN) begin
      act_log[act_n % 64] = '{a: A, d: D};
      act_n++;
    end
  end

  // Analog device: restarts its stream on SEL, shifts the next bit out on
  // each rising SCLK2, LSB of each word first.
  always @(posedge SCLK2 or posedge SEL) begin
    if (SEL) begin
      dev_idx = 0;
    end else if (dev_idx < 64) begin
      SPI_SI = dev_words[dev_idx / 8][dev_idx % 8];
      dev_idx++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    b_s1  = sclk1_n;
    b_s2  = sclk2_n;
    b_sel = sel_n;
    b_act = act_n;
  endtask

  task automatic start(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    ADDR_BGN = addr;
    DATA_LEN = len;
    BGN      = 1'b1;
    step();
  endtask

  task automatic run_to_done(input int lim, output int cyc);
    cyc = 0;
    while (spi_is_done !== 1'b1 && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_writes(input string tag);
    wr_t e;
    int  i;
    chk({tag, "_nwr"}, act_n - b_act, exp_q.size());
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_wr_a"}, act_log[(b_act + i) % 64].a, e.a);
      chk({tag, "_wr_d"}, act_log[(b_act + i) % 64].d, e.d);
      i++;
    end
  endtask

  initial begin
    int cyc;

    // Reset values
    repeat (3) step();
    chk("rst_sclk1", SCLK1, 1'b0);
    chk("rst_sclk2", SCLK2, 1'b0);
    chk("rst_sel", SEL, 1'b0);
    chk("rst_cen", CEN, 1'b1);
    chk("rst_dwe", D_WE, 1'b0);
    chk("rst_a", A, 9'h000);
    chk("rst_d", D, 8'h00);
    chk("rst_done", spi_is_done, 1'b0);
    RST = 1'b0;
    step();
    step();

    // Single word
    dev_words[0] = 8'hA5;
    snap();
    exp_q.push_back('{a: 9'h0A0, d: 8'hA5});
    start(9'h0A0, 8'd1);
    chk("t1_sel_c0", SEL, 1'b1);
    run_to_done(300, cyc);
    chk("t1_done_cyc", cyc, 51);
    chk("t1_sclk1_n", sclk1_n - b_s1, 8);
    chk("t1_sclk2_n", sclk2_n - b_s2, 8);
    chk("t1_sel_n", sel_n - b_sel, 2);
    check_writes("t1");
    step();
    chk("t1_done_hold", spi_is_done, 1'b1);
    BGN = 1'b0;
    step();
    chk("t1_done_clr", spi_is_done, 1'b0);

    // Three words, descending addresses
    dev_words[0] = 8'h3C;
    dev_words[1] = 8'h81;
    dev_words[2] = 8'hFF;
    snap();
    exp_q.push_back('{a: 9'h010, d: 8'h3C});
    exp_q.push_back('{a: 9'h00F, d: 8'h81});
    exp_q.push_back('{a: 9'h00E, d: 8'hFF});
    start(9'h010, 8'd3);
    run_to_done(400, cyc);
    chk("t2_done_cyc", cyc, 149);
    chk("t2_sel_n", sel_n - b_sel, 2);
    chk("t2_sclk1_n", sclk1_n - b_s1, 24);
    chk("t2_sclk2_n", sclk2_n - b_s2, 24);
    check_writes("t2");
    BGN = 1'b0;
    step();

    // Zero-length request
    snap();
    start(9'h077, 8'd0);
    chk("t3_done_c0", spi_is_done, 1'b1);
    repeat (5) step();
    chk("t3_done_hold", spi_is_done, 1'b1);
    chk("t3_cen", CEN, 1'b1);
    chk("t3_sel_n", sel_n - b_sel, 0);
    chk("t3_sclk_n", (sclk1_n - b_s1) + (sclk2_n - b_s2), 0);
    chk("t3_nwr", act_n - b_act, 0);
    BGN = 1'b0;
    step();

    // Address wrap below zero
    dev_words[0] = 8'h12;
    dev_words[1] = 8'hE7;
    snap();
    exp_q.push_back('{a: 9'h000, d: 8'h12});
    exp_q.push_back('{a: 9'h1FF, d: 8'hE7});
    start(9'h000, 8'd2);
    run_to_done(300, cyc);
    chk("t4_done_cyc", cyc, 100);
    check_writes("t4");
    BGN = 1'b0;
    step();

    // Abort during bit 4 of word 2, then a fresh transfer
    dev_words[0] = 8'h6B;
    dev_words[1] = 8'h9D;
    snap();
    exp_q.push_back('{a: 9'h055, d: 8'h6B});
    start(9'h055, 8'd2);
    repeat (77) step();
    BGN = 1'b0;
    step();
    chk("t5_abort_done", spi_is_done, 1'b0);
    chk("t5_abort_cen", CEN, 1'b1);
    chk("t5_abort_sclk", {SCLK1, SCLK2, SEL}, 3'b000);
    repeat (60) step();
    chk("t5_abort_done2", spi_is_done, 1'b0);
    check_writes("t5");
    dev_words[0] = 8'h5A;
    snap();
    exp_q.push_back('{a: 9'h055, d: 8'h5A});
    start(9'h055, 8'd1);
    run_to_done(300, cyc);
    chk("t5_restart_cyc", cyc, 51);
    check_writes("t5r");
    BGN = 1'b0;
    step();

    // Reset during the write cycle, BGN held high afterwards
    dev_words[0] = 8'hC3;
    start(9'h123, 8'd1);
    repeat (50) step();
    chk("t6_we_c50", D_WE, 1'b1);
    chk("t6_a_c50", A, 9'h123);
    RST = 1'b1;
    step();
    chk("t6_rst_dwe", D_WE, 1'b0);
    chk("t6_rst_cen", CEN, 1'b1);
    chk("t6_rst_a", A, 9'h000);
    chk("t6_rst_done", spi_is_done, 1'b0);
    RST = 1'b0;
    snap();
    repeat (100) step();
    chk("t6_hold_done", spi_is_done, 1'b0);
    chk("t6_hold_nwr", act_n - b_act, 0);
    chk("t6_hold_sel", sel_n - b_sel, 0);
    BGN = 1'b0;
    step();
    snap();
    exp_q.push_back('{a: 9'h123, d: 8'hC3});
    start(9'h123, 8'd1);
    run_to_done(300, cyc);
    chk("t6_restart_cyc", cyc, 51);
    check_writes("t6r");
    BGN = 1'b0;
    step();

    chk("invariants", viol_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
